// File: rtl/spi_regs_arb_pkg.sv
// Shared types and constants for the two-requester SPI register-access arbiter.
package spi_regs_arb_pkg;

  localparam int unsigned FRAME_W     = 16;
  localparam int unsigned RD_BIT      = 14;
  localparam int unsigned SCK_DIV_DEF = 4;
  localparam int unsigned GAP_CYC_DEF = 4;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic       rw,
                                                    input logic [5:0] addr,
                                                    input logic [7:0] wdata);
    return {1'b0, rw, addr, rw ? 8'h00 : wdata};
  endfunction

endpackage

// File: rtl/spi_regs_arb_if.sv
// Requester handshake plus SPI pins of the arbiter, grouped as one bundle.
interface spi_regs_arb_if;
  logic       req0, req1;
  logic       rw0, rw1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       busy;
  logic       SCK, CS, SI, SO;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, SO,
    output ack0, ack1, rdata, busy, SCK, CS, SI
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, SO,
    input  ack0, ack1, rdata, busy, SCK, CS, SI
  );
endinterface

// File: rtl/spi_regs_shifter.sv
// TX/RX shift registers and bit counter, stepped by shift/sample strobes from the FSM.
module spi_regs_shifter
  import spi_regs_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               shift,
  input  logic               sample,
  input  logic               so,
  output logic               si,
  output logic               last,
  output logic               is_read,
  output logic [7:0]         rx
);

  logic [FRAME_W-1:0] tx;
  logic [3:0]         bitcnt;

  // bitcnt counts SCK falls so far; rises 9..16 (data byte) see bitcnt 8..15
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= '0;
      rx      <= '0;
      bitcnt  <= '0;
      is_read <= 1'b0;
    end else if (load) begin
      tx      <= frame;
      bitcnt  <= '0;
      is_read <= frame[RD_BIT];
    end else begin
      if (shift) begin
        tx     <= {tx[FRAME_W-2:0], 1'b0};
        bitcnt <= bitcnt + 4'd1;
      end
      if (sample && is_read && bitcnt[3])
        rx <= {rx[6:0], so};
    end
  end

  assign si   = tx[FRAME_W-1];
  assign last = (bitcnt == 4'(FRAME_W - 1));

endmodule

// File: rtl/spi_regs_arb.sv
// Round-robin arbiter between two requesters sharing one SPI register slave.
module spi_regs_arb
  import spi_regs_arb_pkg::*;
#(
  parameter int unsigned SCK_DIV = SCK_DIV_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
)(
  input  logic           FX2_CLK,
  input  logic           reset,
  spi_regs_arb_if.slave  bus
);

  localparam logic [7:0] DIV_M1 = 8'(SCK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(GAP_CYC - 1);

  state_t             state;
  logic [7:0]         cnt;
  logic               armed, prio, owner, done;
  logic               sck, cs, busy, ack0, ack1;
  logic [7:0]         rdata;
  logic               grant_who, start, cnt_zero, shift, sample;
  logic [FRAME_W-1:0] frame;
  logic               si, last, is_read;
  logic [7:0]         rx;

  always_comb begin
    grant_who = (bus.req0 && bus.req1) ? prio : bus.req1;
    frame     = grant_who ? make_frame(bus.rw1, bus.addr1, bus.wdata1)
                          : make_frame(bus.rw0, bus.addr0, bus.wdata0);
    cnt_zero  = (cnt == 8'd0);
    start     = (state == IDLE) && armed && (bus.req0 || bus.req1);
    shift     = (state == SHIFT) && cnt_zero && sck;
    sample    = ((state == SETUP) && cnt_zero) ||
                ((state == SHIFT) && cnt_zero && !sck && !done);
  end

  spi_regs_shifter u_shifter (
    .clk     (FX2_CLK),
    .rst     (reset),
    .load    (start),
    .frame   (frame),
    .shift   (shift),
    .sample  (sample),
    .so      (bus.SO),
    .si      (si),
    .last    (last),
    .is_read (is_read),
    .rx      (rx)
  );

  // armed delays the first grant to the second clock edge after reset release
  always_ff @(posedge FX2_CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
      prio  <= 1'b0;
      owner <= 1'b0;
      done  <= 1'b0;
      sck   <= 1'b0;
      cs    <= 1'b0;
      busy  <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      rdata <= '0;
    end else begin
      armed <= 1'b1;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          owner <= grant_who;
          prio  <= !grant_who;
          cs    <= 1'b1;
          busy  <= 1'b1;
          done  <= 1'b0;
          cnt   <= DIV_M1;
          state <= SETUP;
        end
        SETUP: if (cnt_zero) begin
          sck   <= 1'b1;
          cnt   <= DIV_M1;
          state <= SHIFT;
        end else cnt <= cnt - 8'd1;
        // the 16th SCK low half stays in SHIFT; HOLD follows it
        SHIFT: if (!cnt_zero) cnt <= cnt - 8'd1;
          else if (sck) begin
            sck  <= 1'b0;
            done <= last;
            cnt  <= DIV_M1;
          end else if (done) begin
            cnt   <= DIV_M1;
            state <= HOLD;
          end else begin
            sck <= 1'b1;
            cnt <= DIV_M1;
          end
        HOLD: if (cnt_zero) begin
          cs    <= 1'b0;
          ack0  <= !owner;
          ack1  <= owner;
          if (is_read) rdata <= rx;
          cnt   <= GAP_M1;
          state <= GAP;
        end else cnt <= cnt - 8'd1;
        GAP: if (cnt_zero) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SCK   = sck;
  assign bus.CS    = cs;
  assign bus.SI    = si;
  assign bus.busy  = busy;
  assign bus.ack0  = ack0;
  assign bus.ack1  = ack1;
  assign bus.rdata = rdata;

endmodule

// File: tb/tb_spi_regs_arb.sv
// Randomized bench for spi_regs_arb with an SPI slave model and frame/ack monitor.
module tb_spi_regs_arb;

  localparam int unsigned DIV    = 2;
  localparam int unsigned GAPC   = 4;
  localparam int unsigned CS_LEN = 34 * DIV;
  localparam int unsigned BUDGET = 400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_regs_arb_if bus();

  spi_regs_arb #(.SCK_DIV(DIV), .GAP_CYC(GAPC)) dut (
    .FX2_CLK (clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] bits;
    int unsigned rises;
    int unsigned cs_len;
  } frame_t;

  typedef struct {
    int unsigned who;
    logic [7:0]  rdata;
  } ack_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  frame_t      frame_q[$];
  ack_t        ack_q[$];
  int unsigned gap_q[$];
  logic [7:0]  slave_mem[64];
  logic [7:0]  ref_mem[64];
  logic [7:0]  exp_rd;
  int unsigned dual_ack = 0;

  logic        prev_cs = 1'b0, prev_sck = 1'b0;
  logic [15:0] sh = '0;
  int unsigned rises = 0, falls = 0, cs_len = 0, low_len = 0;
  bit          seen_frame = 1'b0;
  logic        slv_rd = 1'b0;
  logic [5:0]  slv_addr = '0;

  // Bus monitor and SPI slave: reconstructs frames, gaps and acks; serves reads from slave_mem
  always @(negedge clk) begin
    logic [7:0] byte_v;
    frame_t     f;
    ack_t       a;
    if (bus.CS) begin
      if (!prev_cs) begin
        if (seen_frame) gap_q.push_back(low_len);
        rises = 0; falls = 0; sh = '0; cs_len = 0; slv_rd = 1'b0;
      end
      cs_len++;
      if (bus.SCK && !prev_sck) begin
        sh = {sh[14:0], bus.SI};
        rises++;
      end
      if (!bus.SCK && prev_sck) begin
        falls++;
        if (falls == 8) begin
          slv_rd   = sh[6];
          slv_addr = sh[5:0];
        end
        if (slv_rd && falls >= 8 && falls <= 15) begin
          byte_v = slave_mem[slv_addr];
          bus.SO = byte_v[15 - falls];
        end else bus.SO = 1'b0;
      end
    end else begin
      if (prev_cs) begin
        f.bits = sh; f.rises = rises; f.cs_len = cs_len;
        frame_q.push_back(f);
        if (rises == 16 && !sh[14]) slave_mem[sh[13:8]] = sh[7:0];
        seen_frame = 1'b1;
        low_len = 0;
      end
      low_len++;
    end
    if (bus.ack0 && bus.ack1) dual_ack++;
    if (bus.ack0) begin a.who = 0; a.rdata = bus.rdata; ack_q.push_back(a); end
    if (bus.ack1) begin a.who = 1; a.rdata = bus.rdata; ack_q.push_back(a); end
    prev_cs  = bus.CS;
    prev_sck = bus.SCK;
  end

  function automatic logic [15:0] exp_frame(input logic rw, input logic [5:0] a, input logic [7:0] d);
    int unsigned v;
    v = (rw ? 32'h4000 : 32'h0) + a * 256 + (rw ? 32'h0 : 32'(d));
    return v[15:0];
  endfunction

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    frame_q.delete();
    ack_q.delete();
    gap_q.delete();
  endtask

  task automatic drive_req(input int unsigned who, input logic on, input logic rw,
                           input logic [5:0] a, input logic [7:0] d);
    if (who == 0) begin
      bus.req0 = on; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = on; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic wait_ack(input int unsigned who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(BUDGET) && !ok; i++) begin
      @(negedge clk);
      if ((who == 0 && bus.ack0) || (who == 1 && bus.ack1)) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(BUDGET) && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input int unsigned who, input logic rw, input logic [5:0] a,
                         input logic [7:0] d, output bit ok_ack, output bit ok_idle);
    @(negedge clk);
    drive_req(who, 1'b1, rw, a, d);
    wait_ack(who, ok_ack);
    drive_req(who, 1'b0, rw, a, d);
    wait_idle(ok_idle);
    settle();
  endtask

  task automatic test_reset();
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    exp_rd = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.CS !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b expected 0", bus.CS); end
    n_checks++; if (bus.SCK !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", bus.SCK); end
    n_checks++; if (bus.SI !== 1'b0) begin n_fail++; $display("FAIL reset_si: got %b expected 0", bus.SI); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if ({bus.ack0, bus.ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", {bus.ack0, bus.ack1}); end
    n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 clear_q();
  endtask

  task automatic test_write();
    bit ok_a, ok_i;
    ref_mem[3] = 8'hA5;
    run_txn(0, 1'b0, 6'h03, 8'hA5, ok_a, ok_i);
    n_checks++; if (!ok_a || !ok_i) begin n_fail++; $display("FAIL write_timeout: ack %b idle %b expected 1 1", ok_a, ok_i); end
    n_checks++; if (frame_q.size() != 1 || frame_q[0].bits !== 16'h03A5) begin n_fail++;
      $display("FAIL write_frame: got %h (n=%0d) expected 03a5", frame_q.size() ? frame_q[0].bits : 16'hxxxx, frame_q.size()); end
    n_checks++; if (frame_q.size() != 1 || frame_q[0].cs_len != CS_LEN) begin n_fail++;
      $display("FAIL write_cs_len: got %0d expected %0d", frame_q.size() ? frame_q[0].cs_len : 0, CS_LEN); end
    n_checks++; if (ack_q.size() != 1 || ack_q[0].who != 0) begin n_fail++;
      $display("FAIL write_ack: got %0d acks expected one ack0", ack_q.size()); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy: got %b expected 0", bus.busy); end
    clear_q();
  endtask

  task automatic test_read();
    bit ok_a, ok_i;
    slave_mem[2] = 8'h5C;
    ref_mem[2]   = 8'h5C;
    run_txn(1, 1'b1, 6'h02, 8'($urandom), ok_a, ok_i);
    exp_rd = 8'h5C;
    n_checks++; if (!ok_a || !ok_i) begin n_fail++; $display("FAIL read_timeout: ack %b idle %b expected 1 1", ok_a, ok_i); end
    n_checks++; if (frame_q.size() != 1 || frame_q[0].bits !== 16'h4200) begin n_fail++;
      $display("FAIL read_frame: got %h expected 4200", frame_q.size() ? frame_q[0].bits : 16'hxxxx); end
    n_checks++; if (ack_q.size() != 1 || ack_q[0].who != 1 || ack_q[0].rdata !== 8'h5C) begin n_fail++;
      $display("FAIL read_ack: got n=%0d rdata %h expected one ack1 rdata 5c", ack_q.size(), ack_q.size() ? ack_q[0].rdata : 8'hxx); end
    repeat (5) @(negedge clk);
    n_checks++; if (bus.rdata !== 8'h5C) begin n_fail++; $display("FAIL read_hold: got %h expected 5c", bus.rdata); end
    clear_q();
  endtask

  task automatic test_random();
    bit ok_a, ok_i;
    for (int n = 0; n < 16; n++) begin
      int unsigned who;
      logic rw;
      logic [5:0] a;
      logic [7:0] d;
      who = $urandom_range(0, 1);
      rw  = 1'($urandom_range(0, 1));
      a   = 6'($urandom);
      d   = 8'($urandom);
      if (rw) exp_rd = ref_mem[a];
      else    ref_mem[a] = d;
      run_txn(who, rw, a, d, ok_a, ok_i);
      n_checks++; if (!ok_a || !ok_i || frame_q.size() != 1 || frame_q[0].bits !== exp_frame(rw, a, d)) begin n_fail++;
        $display("FAIL rand_frame[%0d]: got %h expected %h", n, frame_q.size() ? frame_q[0].bits : 16'hxxxx, exp_frame(rw, a, d)); end
      n_checks++; if (ack_q.size() != 1 || ack_q[0].who != who) begin n_fail++;
        $display("FAIL rand_ack_who[%0d]: got n=%0d expected one ack%0d", n, ack_q.size(), who); end
      n_checks++; if (ack_q.size() != 1 || ack_q[0].rdata !== exp_rd) begin n_fail++;
        $display("FAIL rand_rdata[%0d]: got %h expected %h", n, ack_q.size() ? ack_q[0].rdata : 8'hxx, exp_rd); end
      clear_q();
    end
  endtask

  task automatic test_drop();
    bit ok_a, ok_i, reached;
    logic [5:0] a;
    logic [7:0] d;
    a = 6'($urandom); d = 8'($urandom);
    ref_mem[a] = d;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, a, d);
    reached = 1'b0;
    for (int i = 0; i < int'(BUDGET) && !reached; i++) begin
      @(negedge clk); #1;
      if (bus.CS && falls >= 3) reached = 1'b1;
    end
    drive_req(0, 1'b0, 1'b1, ~a, ~d);
    wait_ack(0, ok_a);
    wait_idle(ok_i);
    repeat (GAPC + 4) @(negedge clk);
    settle();
    n_checks++; if (!reached || !ok_a || !ok_i) begin n_fail++; $display("FAIL drop_timeout: mid %b ack %b idle %b expected 1 1 1", reached, ok_a, ok_i); end
    n_checks++; if (ack_q.size() != 1 || ack_q[0].who != 0) begin n_fail++; $display("FAIL drop_ack: got %0d acks expected one ack0", ack_q.size()); end
    n_checks++; if (frame_q.size() != 1 || frame_q[0].bits !== exp_frame(1'b0, a, d)) begin n_fail++;
      $display("FAIL drop_frame: got %h expected %h", frame_q.size() ? frame_q[0].bits : 16'hxxxx, exp_frame(1'b0, a, d)); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    bit ok_a, ok_i, reached;
    logic [5:0] a;
    logic [7:0] d;
    a = 6'($urandom); d = 8'($urandom);
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, a, d);
    reached = 1'b0;
    for (int i = 0; i < int'(BUDGET) && !reached; i++) begin
      @(negedge clk); #1;
      if (bus.CS && falls == 6) reached = 1'b1;
    end
    reset = 1'b1;
    exp_rd = 8'h00;
    #1;
    n_checks++; if (!reached || bus.CS !== 1'b0 || bus.SCK !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL midreset_async: reached %b cs %b sck %b busy %b expected 1 0 0 0", reached, bus.CS, bus.SCK, bus.busy); end
    drive_req(0, 1'b0, 1'b0, a, d);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (ack_q.size() != 0) begin n_fail++; $display("FAIL midreset_noack: got %0d acks expected 0", ack_q.size()); end
    n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 00", bus.rdata); end
    clear_q();
    a = 6'($urandom); d = 8'($urandom);
    ref_mem[a] = d;
    run_txn(1, 1'b0, a, d, ok_a, ok_i);
    n_checks++; if (!ok_a || !ok_i || frame_q.size() != 1 || frame_q[0].bits !== exp_frame(1'b0, a, d) || frame_q[0].rises != 16) begin n_fail++;
      $display("FAIL midreset_next: got %h expected %h", frame_q.size() ? frame_q[0].bits : 16'hxxxx, exp_frame(1'b0, a, d)); end
    clear_q();
  endtask

  task automatic test_tie();
    logic [5:0]  ta[2][3];
    logic [7:0]  td[2][3];
    int unsigned c[2];
    bit          ok_i;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 3; j++) begin
        ta[r][j] = 6'($urandom);
        td[r][j] = 8'($urandom);
      end
    @(negedge clk);
    reset = 1'b1;
    exp_rd = 8'h00;
    drive_req(0, 1'b1, 1'b0, ta[0][0], td[0][0]);
    drive_req(1, 1'b1, 1'b0, ta[1][0], td[1][0]);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tie_first_edge: busy %b expected 0", bus.busy); end
    #1 clear_q();
    c[0] = 0; c[1] = 0;
    for (int cyc = 0; cyc < int'(8 * BUDGET) && !(c[0] == 3 && c[1] == 3); cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++)
        if ((r == 0 && bus.ack0) || (r == 1 && bus.ack1)) begin
          c[r]++;
          if (c[r] < 3) drive_req(r, 1'b1, 1'b0, ta[r][c[r]], td[r][c[r]]);
          else          drive_req(r, 1'b0, 1'b0, '0, '0);
        end
    end
    wait_idle(ok_i);
    settle();
    n_checks++; if (c[0] != 3 || c[1] != 3 || !ok_i || ack_q.size() != 6) begin n_fail++;
      $display("FAIL tie_count: acks %0d/%0d queued %0d expected 3/3 6", c[0], c[1], ack_q.size()); end
    for (int k = 0; k < 6 && k < ack_q.size() && k < frame_q.size(); k++) begin
      n_checks++; if (ack_q[k].who != k % 2) begin n_fail++; $display("FAIL tie_order[%0d]: got %0d expected %0d", k, ack_q[k].who, k % 2); end
      n_checks++; if (frame_q[k].bits !== exp_frame(1'b0, ta[k%2][k/2], td[k%2][k/2])) begin n_fail++;
        $display("FAIL tie_frame[%0d]: got %h expected %h", k, frame_q[k].bits, exp_frame(1'b0, ta[k%2][k/2], td[k%2][k/2])); end
      n_checks++; if (frame_q[k].cs_len != CS_LEN) begin n_fail++; $display("FAIL tie_cs_len[%0d]: got %0d expected %0d", k, frame_q[k].cs_len, CS_LEN); end
      ref_mem[ta[k%2][k/2]] = td[k%2][k/2];
    end
    foreach (gap_q[g]) begin
      n_checks++; if (gap_q[g] < GAPC) begin n_fail++; $display("FAIL tie_gap[%0d]: got %0d expected >= %0d", g, gap_q[g], GAPC); end
    end
    n_checks++; if (dual_ack != 0) begin n_fail++; $display("FAIL dual_ack: got %0d expected 0", dual_ack); end
    clear_q();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_random();
    test_drop();
    test_reset_mid();
    test_tie();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
